// File: rtl/mem_stage_pkg.sv
// Shared widths, mem_op codes and zip bundle layouts for the memory stage.
// Field order in the structs is the on-wire MSB-first order of each zip.
package mem_stage_pkg;

  localparam int EXE2MEM_LEN = 92;
  localparam int MEM2WB_LEN  = 87;
  localparam int MEMRF_LEN   = 38;

  localparam logic [3:0] MEMOP_LD_B  = 4'd0;
  localparam logic [3:0] MEMOP_LD_H  = 4'd1;
  localparam logic [3:0] MEMOP_LD_W  = 4'd2;
  localparam logic [3:0] MEMOP_LD_BU = 4'd3;
  localparam logic [3:0] MEMOP_ST_B  = 4'd4;
  localparam logic [3:0] MEMOP_ST_H  = 4'd5;
  localparam logic [3:0] MEMOP_ST_W  = 4'd6;
  localparam logic [3:0] MEMOP_LD_HU = 4'd8;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } exe2mem_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } mem2wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/half at the address offset and extends it.
// Purely combinational (zero latency), no flow control.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] load_word,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_word[{off, 3'b000} +: 8];
    half_sel = off[1] ? load_word[31:16] : load_word[15:0];
    aligned  = load_word;
    case (mem_op)
      MEMOP_LD_B:  aligned = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LD_H:  aligned = {{16{half_sel[15]}}, half_sel};
      MEMOP_LD_W:  aligned = load_word;
      MEMOP_LD_BU: aligned = {24'd0, byte_sel};
      MEMOP_LD_HU: aligned = {16'd0, half_sel};
      default:     aligned = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one-entry register between execute and writeback.
// Output is valid one cycle after accept; holds (and replays buffered load data) while wb_allowin is low.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic                   mem_allowin,
  input  logic                   exe_to_mem_valid,
  input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
  output logic [MEMRF_LEN-1:0]   mem_rf_zip,
  output logic                   mem_ex_flag
);

  logic        mem_valid;
  logic        mem_ready_go;
  logic        first_cycle;
  logic        accept;
  exe2mem_t    mem_zip;
  logic [31:0] rdata_buf;
  logic [31:0] load_word;
  logic [31:0] aligned;
  logic [31:0] final_result;
  logic        rf_we_eff;
  mem2wb_t     wb_zip;

  assign mem_ready_go    = 1'b1;
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign accept          = exe_to_mem_valid & mem_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      first_cycle <= 1'b0;
      rdata_buf   <= 32'd0;
      mem_zip     <= '0;
    end else begin
      if (flush) begin
        mem_valid <= 1'b0;
      end else if (mem_allowin) begin
        mem_valid <= exe_to_mem_valid;
      end
      // SRAM returns data exactly one cycle after the request issued in execute
      first_cycle <= accept;
      if (accept) begin
        mem_zip <= exe2mem_t'(exe_to_mem_zip);
      end
      if (first_cycle) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  assign load_word = first_cycle ? data_sram_rdata : rdata_buf;

  mem_stage_load_align u_load_align (
    .mem_op    (mem_zip.mem_op),
    .off       (mem_zip.alu_result[1:0]),
    .load_word (load_word),
    .aligned   (aligned)
  );

  assign final_result = mem_zip.res_from_mem ? aligned : mem_zip.alu_result;
  // Exception/ertn bundles still flow to writeback but must not write the register file
  assign rf_we_eff    = mem_zip.rf_we & ~mem_zip.ex_valid & ~mem_zip.is_ertn;

  always_comb begin
    wb_zip              = '0;
    wb_zip.rf_we        = rf_we_eff;
    wb_zip.rf_waddr     = mem_zip.rf_waddr;
    wb_zip.final_result = final_result;
    wb_zip.pc           = mem_zip.pc;
    wb_zip.ex_valid     = mem_zip.ex_valid;
    wb_zip.ecode        = mem_zip.ecode;
    wb_zip.esubcode     = mem_zip.esubcode;
    wb_zip.is_ertn      = mem_zip.is_ertn;
  end

  assign mem_to_wb_zip = wb_zip;
  assign mem_rf_zip    = {mem_valid & rf_we_eff, mem_zip.rf_waddr, final_result};
  assign mem_ex_flag   = mem_valid & (mem_zip.ex_valid | mem_zip.is_ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then randomized traffic.
// Expected writeback bundles are queued on accept and compared by a negedge monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   mem_allowin;
  logic                   exe_to_mem_valid;
  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip;
  logic [31:0]            data_sram_rdata;
  logic                   wb_allowin;
  logic                   mem_to_wb_valid;
  logic [MEM2WB_LEN-1:0]  mem_to_wb_zip;
  logic [MEMRF_LEN-1:0]   mem_rf_zip;
  logic                   mem_ex_flag;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_zip   (exe_to_mem_zip),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_zip    (mem_to_wb_zip),
    .mem_rf_zip       (mem_rf_zip),
    .mem_ex_flag      (mem_ex_flag)
  );

  mem2wb_t     sb[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic        pend_vld = 1'b0;
  logic [31:0] pend_rd = 32'd0;
  logic [31:0] idle_rd = 32'hDEAD_DEAD;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what writeback should see for a bundle whose SRAM word is rd
  function automatic mem2wb_t model(input exe2mem_t z, input logic [31:0] rd);
    mem2wb_t     w;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] ld;
    int unsigned off;
    off = z.alu_result[1:0];
    b   = (rd >> (8 * off)) & 32'hFF;
    h   = (off >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    case (z.mem_op)
      4'd0:    ld = (b > 127) ? b + 32'hFFFF_FF00 : b;
      4'd1:    ld = (h > 32767) ? h + 32'hFFFF_0000 : h;
      4'd3:    ld = b;
      4'd8:    ld = h;
      default: ld = rd;
    endcase
    w.rf_we        = z.rf_we && !z.ex_valid && !z.is_ertn;
    w.rf_waddr     = z.rf_waddr;
    w.final_result = z.res_from_mem ? ld : z.alu_result;
    w.pc           = z.pc;
    w.ex_valid     = z.ex_valid;
    w.ecode        = z.ecode;
    w.esubcode     = z.esubcode;
    w.is_ertn      = z.is_ertn;
    return w;
  endfunction

  function automatic exe2mem_t mk(input logic res, input logic we, input logic [4:0] wa,
                                  input logic [31:0] alu, input logic [3:0] op,
                                  input logic [31:0] pc, input logic exv,
                                  input logic [5:0] ec, input logic ertn);
    exe2mem_t z;
    z.res_from_mem = res;
    z.rf_we        = we;
    z.rf_waddr     = wa;
    z.alu_result   = alu;
    z.mem_op       = op;
    z.pc           = pc;
    z.ex_valid     = exv;
    z.ecode        = ec;
    z.esubcode     = 9'(pc[8:0]);
    z.is_ertn      = ertn;
    return z;
  endfunction

  // One cycle: drive at posedge+1, optional direct result check at negedge, update model after edge
  task automatic step(input logic v, input exe2mem_t z, input logic [31:0] rd, input logic wb,
                      input logic fl, input logic rst, input logic chk, input logic [31:0] cv,
                      input string nm);
    logic    acc;
    mem2wb_t w;
    exe_to_mem_valid = v;
    exe_to_mem_zip   = z;
    wb_allowin       = wb;
    flush            = fl;
    reset            = rst;
    data_sram_rdata  = pend_vld ? pend_rd : idle_rd;
    acc = v && ((sb.size() == 0) || wb);
    @(negedge clk);
    if (chk) begin
      w = mem_to_wb_zip;
      check(nm, {mem_to_wb_valid, w.final_result}, {1'b1, cv});
    end
    @(posedge clk);
    #1;
    if (rst || fl) sb.delete();
    else if (acc) sb.push_back(model(z, rd));
    pend_vld = acc;
    pend_rd  = rd;
  endtask

  always @(negedge clk) begin
    mem2wb_t e;
    if (mon_en) begin
      check("allowin", mem_allowin, (sb.size() == 0) || wb_allowin);
      check("wb_valid", mem_to_wb_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        e = sb[0];
        check("wb_zip", mem_to_wb_zip, e);
        check("rf_zip", mem_rf_zip, {e.rf_we, e.rf_waddr, e.final_result});
        check("ex_flag", mem_ex_flag, e.ex_valid | e.is_ertn);
        if (wb_allowin) void'(sb.pop_front());
      end else begin
        check("rf_zip_idle", mem_rf_zip[37], 1'b0);
        check("ex_flag_idle", mem_ex_flag, 1'b0);
      end
    end
  end

  initial begin
    exe2mem_t    nop;
    exe2mem_t    z;
    logic [3:0]  ops [9];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd4, 4'd5, 4'd6, 4'hF};
    nop = mk(1'b0, 1'b0, 5'd0, 32'd0, 4'd2, 32'd0, 1'b0, 6'd0, 1'b0);
    reset = 1'b1; flush = 1'b0; exe_to_mem_valid = 1'b0; exe_to_mem_zip = '0;
    wb_allowin = 1'b1; data_sram_rdata = 32'd0;
    @(posedge clk);
    #1;
    step(0, nop, 0, 1, 0, 1, 0, 0, "rst");
    mon_en = 1'b1;
    step(0, nop, 0, 1, 0, 0, 0, 0, "idle");

    // LD_B sign extension at offset 3
    step(1, mk(1, 1, 5'd3, 32'h1003, 4'd0, 32'h1C00_0000, 0, 0, 0), 32'h80FF_1234, 1, 0, 0, 0, 0, "");
    step(0, nop, 0, 1, 0, 0, 1, 32'hFFFF_FF80, "ld_b_sext");

    // LD_HU stalled three cycles; SRAM word changes after the first
    step(1, mk(1, 1, 5'd4, 32'h2002, 4'd8, 32'h1C00_0004, 0, 0, 0), 32'hBEEF_0000, 1, 0, 0, 0, 0, "");
    for (int i = 0; i < 3; i++) step(0, nop, 0, 0, 0, 0, 1, 32'h0000_BEEF, "ld_hu_stall");
    step(0, nop, 0, 1, 0, 0, 1, 32'h0000_BEEF, "ld_hu_drain");

    // Back-to-back LD_W with writeback always ready
    step(1, mk(1, 1, 5'd5, 32'h3000, 4'd2, 32'h1C00_0008, 0, 0, 0), 32'h1111_1111, 1, 0, 0, 0, 0, "");
    step(1, mk(1, 1, 5'd6, 32'h3004, 4'd2, 32'h1C00_000C, 0, 0, 0), 32'h2222_2222, 1, 0, 0, 1, 32'h1111_1111, "b2b_a");
    step(0, nop, 0, 1, 0, 0, 1, 32'h2222_2222, "b2b_b");

    // Flush while a load is stalled, then an ALU bundle
    step(1, mk(1, 1, 5'd7, 32'h4000, 4'd2, 32'h1C00_0010, 0, 0, 0), 32'h3333_3333, 1, 0, 0, 0, 0, "");
    step(0, nop, 0, 0, 0, 0, 1, 32'h3333_3333, "pre_flush");
    step(0, nop, 0, 0, 1, 0, 0, 0, "");
    step(1, mk(0, 1, 5'd8, 32'h55, 4'hF, 32'h1C00_0014, 0, 0, 0), 32'h0, 0, 0, 0, 0, 0, "");
    step(0, nop, 0, 1, 0, 0, 1, 32'h55, "alu_after_flush");

    // Exception bundle: travels to writeback without register write
    step(1, mk(0, 1, 5'd9, 32'h66, 4'hF, 32'h1C00_0100, 1, 6'h0B, 0), 32'h0, 1, 0, 0, 0, 0, "");
    step(0, nop, 0, 1, 0, 0, 1, 32'h66, "exc_bundle");

    // Reset while a load is stalled
    step(1, mk(1, 1, 5'd10, 32'h5000, 4'd2, 32'h1C00_0018, 0, 0, 0), 32'h7777_7777, 1, 0, 0, 0, 0, "");
    step(0, nop, 0, 0, 0, 0, 0, 0, "");
    step(0, nop, 0, 0, 0, 1, 0, 0, "");
    step(0, nop, 0, 0, 0, 0, 0, 0, "");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      z = mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, ops[$urandom_range(0, 8)],
             $urandom, ($urandom_range(0, 7) == 0), 6'($urandom), ($urandom_range(0, 15) == 0));
      idle_rd = $urandom;
      step(($urandom_range(0, 9) < 7), z, $urandom, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 79) == 0), 0, 0, "");
    end
    for (int n = 0; n < 3; n++) step(0, nop, 0, 1, 0, 0, 0, 0, "");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
